wb_regfile_ctrl: RTL
====================

Name: wb_regfile_ctrl

Overview:
Parametrised write-back stage for the PIPE Y86-64 core. It merges the W pipeline register, the architectural register file and retire/halt control into one block. It replaces the fixed write_back stage with a configurable register count and data width, explicit stall/bubble control, and a halt state machine that freezes architectural state on a non-AOK status. It also provides a retired-instruction counter. It sits between memory (m_*/M_* outputs) and decode, whose read ports it serves.

Parameters:
DATA_W, 64, register/data width in bits
RID_W, 4, register-ID width; ID all-ones = RNONE
NREG, 15, number of architectural registers (IDs 0..NREG-1)
CNT_W, 32, retired-instruction counter width
BYPASS, 1, 1 = read port returns same-cycle write data (write-first); 0 = returns old value

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
W_stall  in  1  hold W register contents
W_bubble  in  1  load a bubble into W
m_stat  in  2  status from memory stage (0 AOK, 1 HLT, 2 ADR, 3 INS)
M_icode  in  4  icode from M register
M_valE  in  DATA_W  ALU result from M register
m_valM  in  DATA_W  memory read data
M_dstE  in  RID_W  destination for valE
M_dstM  in  RID_W  destination for valM
d_srcA, d_srcB  in  RID_W  decode read addresses
W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM  out  2/4/DATA_W/DATA_W/RID_W/RID_W  W register
W_valid  out  1  W holds a real (non-bubble) instruction
rf_valA, rf_valB  out  DATA_W  combinational register reads
halted  out  1  halt state reached
stat_out  out  2  final status (AOK while running)
retired  out  CNT_W  count of retired instructions

Behaviour:
- Reset (rst_n=0 at posedge), overriding all other inputs:
  - W_icode=1 (NOP), W_stat=0, W_valE=W_valM=0, W_dstE=W_dstM=RNONE, W_valid=0
  - all registers 0; halted=0; stat_out=0; retired=0
  - reset mid-halt returns to RUN.
- FSM has two states, RUN and HALT.
- In RUN, the W register updates each posedge. Priority: W_bubble > W_stall > load.
  - Load: W_* <= M/m inputs; W_valid=1.
  - Bubble: same values as reset for the W register.
  - Stall: W holds.
- RF write at the same posedge uses the current W contents. It is enabled only when RUN, W_valid=1 and W_stat=AOK:
  - W_dstE written with W_valE if W_dstE < NREG.
  - W_dstM written with W_valM if W_dstM < NREG.
  - If W_dstE == W_dstM (both valid), W_valM wins.
  - IDs >= NREG, including RNONE, are ignored silently.
- RF reads: rf_valX = reg[d_srcX] if d_srcX < NREG, else 0.
  - BYPASS=1: a read address matching an enabled write this cycle returns the write data, with the same valM-over-valE priority.
- retired increments by 1 on each posedge where RUN, W_valid=1 and W_stat=AOK, and W_stall=0 (a stalled instruction is counted once, on the cycle it leaves W). It saturates at all-ones.
- RUN -> HALT on a posedge where W_valid=1 and W_stat != AOK. On that edge:
  - no RF write and no retire increment
  - stat_out <= W_stat; halted <= 1
- HALT is absorbing. W register, RF and retired are frozen regardless of stall/bubble. Reads remain functional for inspection. Exit is by reset only.
- A bubble or stall on the halting edge does not block the transition.
- Outputs are registered, except rf_valA/rf_valB.

Decomposition:
- Shared package y86_pkg holds:
  - stat encodings: SAOK, SHLT, SADR, SINS
  - icode constants: IHALT=0, INOP=1, …
  - RNONE
  - default DATA_W and RID_W
- One sub-module, wb_rf (NREG x DATA_W storage, two write ports with priority, two read ports with optional bypass).
- The W register, FSM and counter stay in the top.

Test Plan:
1. Reset, then load M_icode=2, M_dstE=3, M_valE=0x55, W_stat=AOK, M_dstM=F. One edge later W_valE=0x55. After the next edge reg3=0x55, d_srcA=3 gives rf_valA=0x55, and retired=1.
2. W holds dstE=4 valE=0x11 and dstM=4 valM=0x22, AOK. Result: reg4=0x22. With BYPASS=1, d_srcB=4 shows 0x22 before the edge.
3. Hold W_stall=1 for 3 cycles with a valid AOK instruction in W. Result: W unchanged and retired increments once, only after the stall releases. W_bubble=1 gives W_icode=1, W_valid=0, no write and no increment.
4. m_stat=1 (HLT) with dstE=5 valE=0x99 loaded. On the next edge halted=1, stat_out=1, reg5 unchanged and retired unchanged. Further loads are ignored for 10 cycles.
5. m_stat=2 (ADR), then halted=1 and stat_out=2. Drive rst_n=0 for one edge: halted=0, stat_out=0, all registers 0, W_icode=1.
6. NREG=8, RID_W=4 instance: a write to ID 9 is dropped and a read of ID 9 gives 0. With CNT_W=3 and 9 retires, retired=7 (saturates).

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, icodes, register-ID constants and
// default widths used by the write-back stage and register file.
package y86_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int RID_W_DEF  = 4;

    // Pipeline status codes
    typedef enum logic [1:0] {
        SAOK = 2'd0,
        SHLT = 2'd1,
        SADR = 2'd2,
        SINS = 2'd3
    } stat_e;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // "No register" ID for the default register-ID width
    localparam logic [RID_W_DEF-1:0] RNONE = '1;

    // Write-back control states
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_rf.sv
// Architectural register file: NREG x DATA_W storage, two write ports
// (M port beats E port on a shared address), two combinational read ports
// with optional write-first bypass. Out-of-range IDs are ignored on write
// and read as zero.
module wb_rf
    import y86_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RID_W  = RID_W_DEF,
    parameter int NREG   = 15,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_e_i,
    input  logic [RID_W-1:0]  e_addr_i,
    input  logic [DATA_W-1:0] e_data_i,
    input  logic              we_m_i,
    input  logic [RID_W-1:0]  m_addr_i,
    input  logic [DATA_W-1:0] m_data_i,
    input  logic [RID_W-1:0]  a_addr_i,
    input  logic [RID_W-1:0]  b_addr_i,
    output logic [DATA_W-1:0] a_data_o,
    output logic [DATA_W-1:0] b_data_o
);

    localparam logic [RID_W:0] NREG_W = (RID_W + 1)'(NREG);

    logic [DATA_W-1:0] regs_q [NREG];
    logic              e_hit;
    logic              m_hit;

    // A write port is live only when enabled and addressing a real register
    always_comb begin
        e_hit = we_e_i && ({1'b0, e_addr_i} < NREG_W);
        m_hit = we_m_i && ({1'b0, m_addr_i} < NREG_W);
    end

    // Register storage; M port has priority over E port on the same ID
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (m_hit && (m_addr_i == RID_W'(i))) begin
                    regs_q[i] <= m_data_i;
                end else if (e_hit && (e_addr_i == RID_W'(i))) begin
                    regs_q[i] <= e_data_i;
                end
            end
        end
    end

    // Read ports with optional same-cycle bypass (valM over valE)
    always_comb begin
        a_data_o = '0;
        b_data_o = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (a_addr_i == RID_W'(i)) a_data_o = regs_q[i];
            if (b_addr_i == RID_W'(i)) b_data_o = regs_q[i];
        end
        if (BYPASS != 0) begin
            if (e_hit && (a_addr_i == e_addr_i)) a_data_o = e_data_i;
            if (m_hit && (a_addr_i == m_addr_i)) a_data_o = m_data_i;
            if (e_hit && (b_addr_i == e_addr_i)) b_data_o = e_data_i;
            if (m_hit && (b_addr_i == m_addr_i)) b_data_o = m_data_i;
        end
    end

endmodule

// File: rtl/wb_regfile_ctrl.sv
// Y86-64 write-back stage: W pipeline register, register file, retire counter
// and a RUN/HALT machine that freezes architectural state on a non-AOK status.
module wb_regfile_ctrl
    import y86_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RID_W  = RID_W_DEF,
    parameter int NREG   = 15,
    parameter int CNT_W  = 32,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              W_stall,
    input  logic              W_bubble,
    input  logic [1:0]        m_stat,
    input  logic [3:0]        M_icode,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [RID_W-1:0]  M_dstE,
    input  logic [RID_W-1:0]  M_dstM,
    input  logic [RID_W-1:0]  d_srcA,
    input  logic [RID_W-1:0]  d_srcB,
    output logic [1:0]        W_stat,
    output logic [3:0]        W_icode,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM,
    output logic [RID_W-1:0]  W_dstE,
    output logic [RID_W-1:0]  W_dstM,
    output logic              W_valid,
    output logic [DATA_W-1:0] rf_valA,
    output logic [DATA_W-1:0] rf_valB,
    output logic              halted,
    output logic [1:0]        stat_out,
    output logic [CNT_W-1:0]  retired
);

    wb_state_e         state_q;
    logic [1:0]        stat_q;
    logic [3:0]        icode_q;
    logic [DATA_W-1:0] valE_q;
    logic [DATA_W-1:0] valM_q;
    logic [RID_W-1:0]  dstE_q;
    logic [RID_W-1:0]  dstM_q;
    logic              valid_q;
    logic              halted_q;
    logic [1:0]        stat_out_q;
    logic [CNT_W-1:0]  retired_q;
    logic [CNT_W-1:0]  retired_d;
    logic              commit;
    logic              halt_now;

    // Commit/halt qualification and saturating retire count
    always_comb begin
        commit    = (state_q == RUN) && valid_q && (stat_q == SAOK);
        halt_now  = (state_q == RUN) && valid_q && (stat_q != SAOK);
        retired_d = retired_q;
        if (commit && !W_stall && (retired_q != '1)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // RUN/HALT machine with W register and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            stat_q     <= SAOK;
            icode_q    <= INOP;
            valE_q     <= '0;
            valM_q     <= '0;
            dstE_q     <= '1;
            dstM_q     <= '1;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            stat_out_q <= SAOK;
            retired_q  <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt_now) begin
                        // W keeps the faulting instruction for inspection
                        state_q    <= HALT;
                        halted_q   <= 1'b1;
                        stat_out_q <= stat_q;
                    end else begin
                        retired_q <= retired_d;
                        if (W_bubble) begin
                            stat_q  <= SAOK;
                            icode_q <= INOP;
                            valE_q  <= '0;
                            valM_q  <= '0;
                            dstE_q  <= '1;
                            dstM_q  <= '1;
                            valid_q <= 1'b0;
                        end else if (!W_stall) begin
                            stat_q  <= m_stat;
                            icode_q <= M_icode;
                            valE_q  <= M_valE;
                            valM_q  <= m_valM;
                            dstE_q  <= M_dstE;
                            dstM_q  <= M_dstM;
                            valid_q <= 1'b1;
                        end
                    end
                end
                default: ; // HALT: everything frozen until reset
            endcase
        end
    end

    wb_rf #(
        .DATA_W (DATA_W),
        .RID_W  (RID_W),
        .NREG   (NREG),
        .BYPASS (BYPASS)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_e_i   (commit),
        .e_addr_i (dstE_q),
        .e_data_i (valE_q),
        .we_m_i   (commit),
        .m_addr_i (dstM_q),
        .m_data_i (valM_q),
        .a_addr_i (d_srcA),
        .b_addr_i (d_srcB),
        .a_data_o (rf_valA),
        .b_data_o (rf_valB)
    );

    assign W_stat   = stat_q;
    assign W_icode  = icode_q;
    assign W_valE   = valE_q;
    assign W_valM   = valM_q;
    assign W_dstE   = dstE_q;
    assign W_dstM   = dstM_q;
    assign W_valid  = valid_q;
    assign halted   = halted_q;
    assign stat_out = stat_out_q;
    assign retired  = retired_q;

endmodule
